// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the ULPI link-side controller.
//   BYTE_W       : width of one ULPI bus byte
//   NUM_BYTES    : default transmit buffer depth in bytes
//   SYNC_STAGES  : flops in the ulpi_clk sampling chain (2 sync + 1 edge)
//   ST_*         : FSM state encodings, kept as plain constants so older
//                  blocks that compare raw state bits still line up
// -----------------------------------------------------------------------------
package usb_pkg;

  localparam int BYTE_W      = 8;
  localparam int NUM_BYTES   = 66;
  localparam int SYNC_STAGES = 3;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TURN = 3'd1;
  localparam logic [2:0] ST_RX   = 3'd2;
  localparam logic [2:0] ST_TX   = 3'd3;
  localparam logic [2:0] ST_STOP = 3'd4;

endpackage : usb_pkg

// File: rtl/usb_state_machine_edge_detect.sv
// -----------------------------------------------------------------------------
// ulpi_edge_detect
// Samples the PHY's ulpi_clk as ordinary data in the clk domain and produces a
// one-clk pulse for every rising edge.
//   clk      in  : fast system clock (>= 3x ulpi_clk)
//   rst      in  : asynchronous active-high reset
//   ulpi_clk in  : 60 MHz PHY clock, treated as an asynchronous data input
//   uedge    out : one-clk pulse per ulpi_clk rising edge
// -----------------------------------------------------------------------------
module ulpi_edge_detect
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ulpi_clk,
  output logic uedge
);

  // Bit 0 is the metastability catcher, bit 1 is the first safe copy and
  // bit 2 remembers the previous safe value for the edge compare.
  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], ulpi_clk};
    end
  end

  assign uedge = sync_reg[1] & ~sync_reg[2];

endmodule : ulpi_edge_detect

// File: rtl/usb_state_machine.sv
// -----------------------------------------------------------------------------
// usb_state_machine
// ULPI link-side controller. Filters RX CMD bytes out of the receive stream and
// serialises a wide transmit buffer onto the 8-bit ULPI bus LSB byte first,
// followed by one ulpi period of stp.
//   NUM_BYTES         : transmit buffer depth in bytes
//   clk               in  : system clock
//   rst               in  : asynchronous active-high reset
//   ulpi_clk          in  : PHY clock, edge-detected as data
//   dir               in  : 1 = PHY owns the bus
//   nxt               in  : with dir=1, marks a packet data byte
//   data_in           in  : ULPI bus from the PHY
//   shift_out         in  : start-transmit request (honoured only in IDLE)
//   internal_data_in  in  : transmit buffer, byte k at [8k+7:8k]
//   data_out          out : ULPI bus toward the PHY
//   internal_data_out out : last received data byte
//   new_byte          out : level, high while received data bytes stream
//   stp               out : end-of-transmit stop
// -----------------------------------------------------------------------------
module usb_state_machine
  import usb_pkg::BYTE_W;
  import usb_pkg::state_t;
  import usb_pkg::ST_IDLE;
  import usb_pkg::ST_TURN;
  import usb_pkg::ST_RX;
  import usb_pkg::ST_TX;
  import usb_pkg::ST_STOP;
#(
  parameter int NUM_BYTES = 66
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ulpi_clk,
  input  logic                          dir,
  input  logic                          nxt,
  input  logic [BYTE_W-1:0]             data_in,
  input  logic                          shift_out,
  input  logic [BYTE_W*NUM_BYTES-1:0]   internal_data_in,
  output logic [BYTE_W-1:0]             data_out,
  output logic [BYTE_W-1:0]             internal_data_out,
  output logic                          new_byte,
  output logic                          stp
);

  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam int BUF_W = BYTE_W * NUM_BYTES;

  logic uedge;

  ulpi_edge_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .ulpi_clk (ulpi_clk),
    .uedge    (uedge)
  );

  state_t              state_reg,    state_next;
  logic [BUF_W-1:0]    shift_reg,    shift_next;
  logic [CNT_W-1:0]    cnt_reg,      cnt_next;
  logic [BYTE_W-1:0]   rx_data_reg,  rx_data_next;
  logic                new_byte_reg, new_byte_next;

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    cnt_next      = cnt_reg;
    rx_data_next  = rx_data_reg;
    // new_byte is a level that only survives while data bytes keep coming.
    new_byte_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A PHY taking the bus beats any pending transmit request.
        if (dir) begin
          state_next = ST_TURN;
        end else if (shift_out) begin
          shift_next = internal_data_in;
          cnt_next   = '0;
          state_next = ST_TX;
        end
      end

      ST_TURN: begin
        // data_in is not valid during turnaround; wait for a ulpi edge.
        if (!dir) begin
          state_next = ST_IDLE;
        end else if (uedge) begin
          state_next = ST_RX;
        end
      end

      ST_RX: begin
        if (!dir) begin
          state_next = ST_IDLE;
        end else if (nxt) begin
          rx_data_next  = data_in;
          new_byte_next = 1'b1;
        end
        // dir=1, nxt=0 is an RX CMD: byte held, new_byte drops.
      end

      ST_TX: begin
        if (dir) begin
          // PHY aborts the transmit by grabbing the bus.
          shift_next = '0;
          state_next = ST_TURN;
        end else if (uedge) begin
          if (cnt_reg == LAST_BYTE) begin
            shift_next = '0;
            state_next = ST_STOP;
          end else begin
            shift_next = shift_reg >> BYTE_W;
            cnt_next   = cnt_reg + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (uedge) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      rx_data_reg  <= '0;
      new_byte_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      cnt_reg      <= cnt_next;
      rx_data_reg  <= rx_data_next;
      new_byte_reg <= new_byte_next;
    end
  end

  // Outputs decode straight from registers, so byte 0 is on the bus in the
  // clk right after the load and stp tracks the STOP state exactly.
  assign data_out          = (state_reg == ST_TX) ? shift_reg[BYTE_W-1:0] : '0;
  assign stp               = (state_reg == ST_STOP);
  assign internal_data_out = rx_data_reg;
  assign new_byte          = new_byte_reg;

endmodule : usb_state_machine

// File: tb/tb_usb_state_machine.sv
// -----------------------------------------------------------------------------
// tb_usb_state_machine
// Directed bench for usb_state_machine: reset, RX CMD filtering, RX data
// streaming, full 66-byte transmit with stp, transmit abort and reset during
// stop. clk period 10 ns, ulpi_clk period 30 ns with its rising edges offset
// from clk so the synchroniser timing is deterministic.
// -----------------------------------------------------------------------------
module tb_usb_state_machine;

  localparam int NB = 66;

  logic            clk = 1'b0;
  logic            rst;
  logic            ulpi_clk = 1'b0;
  logic            dir;
  logic            nxt;
  logic [7:0]      data_in;
  logic            shift_out;
  logic [NB*8-1:0] internal_data_in;
  logic [7:0]      data_out;
  logic [7:0]      internal_data_out;
  logic            new_byte;
  logic            stp;

  int n_checks = 0;
  int n_pass   = 0;

  usb_state_machine #(.NUM_BYTES(NB)) dut (
    .clk               (clk),
    .rst               (rst),
    .ulpi_clk          (ulpi_clk),
    .dir               (dir),
    .nxt               (nxt),
    .data_in           (data_in),
    .shift_out         (shift_out),
    .internal_data_in  (internal_data_in),
    .data_out          (data_out),
    .internal_data_out (internal_data_out),
    .new_byte          (new_byte),
    .stp               (stp)
  );

  always #5 clk = ~clk;

  initial begin
    #7;
    forever begin
      ulpi_clk = 1'b1;
      #15;
      ulpi_clk = 1'b0;
      #15;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ends 3 negedges after a ulpi rising edge, with shift_out raised so the
  // load lands after that edge's pulse has already gone by.
  task automatic start_tx();
    @(posedge ulpi_clk);
    clks(3);
    shift_out = 1'b1;
  endtask

  initial begin
    rst = 1'b1; dir = 1'b0; nxt = 1'b0; shift_out = 1'b0; data_in = 8'h00;
    for (int k = 0; k < NB; k++)
      internal_data_in[8*k +: 8] = (k % 2 == 0) ? 8'hBB : 8'hAA;

    // Reset
    clks(3);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_int_out", 32'(internal_data_out), 32'h00);
    check("rst_new_byte", 32'(new_byte), 32'h0);
    check("rst_stp", 32'(stp), 32'h0);
    rst = 1'b0;
    clks(2);
    check("rel_new_byte", 32'(new_byte), 32'h0);
    $display("txn reset done");

    // RX CMD only
    dir = 1'b1; data_in = 8'hFF;
    clks(8);
    check("rxcmd_ff_new_byte", 32'(new_byte), 32'h0);
    data_in = 8'h00;
    clks(4);
    check("rxcmd_00_new_byte", 32'(new_byte), 32'h0);
    check("rxcmd_int_out", 32'(internal_data_out), 32'h00);
    dir = 1'b0;
    clks(2);
    $display("txn rx_cmd_only done");

    // RX data after turnaround and an RX CMD
    dir = 1'b1; nxt = 1'b0; data_in = 8'h10;
    clks(8);
    check("rx_cmd10_new_byte", 32'(new_byte), 32'h0);
    nxt = 1'b1; data_in = 8'hAA;
    clks(2);
    check("rx_aa_new_byte", 32'(new_byte), 32'h1);
    check("rx_aa_data", 32'(internal_data_out), 32'hAA);
    $display("txn rx_data 0xaa");

    // Multiple RX bytes
    clks(1);
    data_in = 8'hFF;
    clks(3);
    check("rx_ff_data", 32'(internal_data_out), 32'hFF);
    check("rx_ff_new_byte", 32'(new_byte), 32'h1);
    data_in = 8'hAA;
    clks(3);
    check("rx_aa2_data", 32'(internal_data_out), 32'hAA);
    check("rx_aa2_new_byte", 32'(new_byte), 32'h1);
    $display("txn rx_multi done");

    // RX CMD mid-stream holds the byte
    nxt = 1'b0; data_in = 8'h22;
    clks(1);
    check("rx_hold_new_byte", 32'(new_byte), 32'h0);
    check("rx_hold_data", 32'(internal_data_out), 32'hAA);
    nxt = 1'b1; data_in = 8'h55;
    clks(2);
    check("rx_55_data", 32'(internal_data_out), 32'h55);
    check("rx_55_new_byte", 32'(new_byte), 32'h1);

    // Dropping dir clears new_byte
    dir = 1'b0;
    clks(1);
    check("rx_drop_new_byte", 32'(new_byte), 32'h0);
    check("rx_drop_data", 32'(internal_data_out), 32'h55);
    nxt = 1'b0; data_in = 8'h00;
    clks(2);
    $display("txn rx_drop done");

    // Full transmit
    start_tx();
    @(posedge ulpi_clk);
    clks(2);
    shift_out = 1'b0;
    check("tx_byte0", 32'(data_out), 32'hBB);
    check("tx_byte0_stp", 32'(stp), 32'h0);
    for (int k = 1; k < NB; k++) begin
      @(posedge ulpi_clk);
      clks(2);
      check($sformatf("tx_byte%0d", k), 32'(data_out), (k % 2 == 1) ? 32'hAA : 32'hBB);
      check($sformatf("tx_byte%0d_stp", k), 32'(stp), 32'h0);
    end
    @(posedge ulpi_clk);
    clks(2);
    check("tx_stop_stp", 32'(stp), 32'h1);
    check("tx_stop_data", 32'(data_out), 32'h00);
    @(posedge ulpi_clk);
    clks(2);
    check("tx_idle_stp", 32'(stp), 32'h0);
    check("tx_idle_data", 32'(data_out), 32'h00);
    $display("txn tx %0d bytes done", NB);

    // Abort mid-transmit
    start_tx();
    @(posedge ulpi_clk);
    clks(2);
    shift_out = 1'b0;
    check("abort_byte0", 32'(data_out), 32'hBB);
    @(posedge ulpi_clk);
    clks(2);
    check("abort_byte1", 32'(data_out), 32'hAA);
    dir = 1'b1;
    clks(1);
    check("abort_data", 32'(data_out), 32'h00);
    check("abort_stp", 32'(stp), 32'h0);
    shift_out = 1'b1;
    clks(6);
    check("abort_ign_data", 32'(data_out), 32'h00);
    check("abort_ign_stp", 32'(stp), 32'h0);
    check("abort_ign_new_byte", 32'(new_byte), 32'h0);
    shift_out = 1'b0; dir = 1'b0;
    clks(2);
    dir = 1'b1; shift_out = 1'b1;
    clks(1);
    check("idle_dir_ign_data", 32'(data_out), 32'h00);
    clks(5);
    check("idle_dir_ign_data2", 32'(data_out), 32'h00);
    shift_out = 1'b0; dir = 1'b0;
    clks(2);
    $display("txn abort done");

    // Reset while in STOP
    start_tx();
    @(posedge ulpi_clk);
    clks(2);
    shift_out = 1'b0;
    for (int k = 1; k <= NB; k++) begin
      @(posedge ulpi_clk);
      clks(2);
    end
    check("rst_tx_stop_stp", 32'(stp), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_stp", 32'(stp), 32'h0);
    check("rst_async_data", 32'(data_out), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    clks(2);
    check("rst_rel_stp", 32'(stp), 32'h0);
    check("rst_rel_data", 32'(data_out), 32'h00);
    $display("txn reset_in_stop done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_usb_state_machine

// File: doc/usb_state_machine.md
# usb_state_machine

ULPI link-side controller between an external USB PHY and the packet logic. Runs on the fast system clock and samples the PHY's `ulpi_clk` as a data input to time byte transfers. Receive: it filters RX CMD bytes from packet data and presents data bytes to internal logic. Transmit: it serialises a wide internal buffer onto the 8-bit ULPI bus, least-significant byte first, then asserts `stp`.

## Interface
- `NUM_BYTES`, default 66: transmit buffer depth in bytes; the buffer is 8*NUM_BYTES = 528 bits.
- `clk` in 1: system clock (about 180 MHz; at least 3x `ulpi_clk`).
- `rst` in 1: reset, asynchronous and active-high.
- `ulpi_clk` in 1: 60 MHz PHY clock, treated as data and edge-detected in the `clk` domain.
- `dir` in 1: PHY bus direction; 1 = PHY drives `data_in`.
- `nxt` in 1: PHY next; with `dir`=1, 1 marks a packet data byte.
- `data_in` in 8: ULPI bus from the PHY.
- `shift_out` in 1: start-transmit request.
- `internal_data_in` in 8*NUM_BYTES: transmit buffer; byte k is bits [8k+7:8k].
- `data_out` out 8: ULPI bus toward the PHY.
- `internal_data_out` out 8: last received data byte.
- `new_byte` out 1: a received data byte is valid on `internal_data_out`.
- `stp` out 1: end-of-transmit stop.

## Operation
- Edge detect: a two-flop synchroniser on `ulpi_clk` feeds an edge register. `uedge` = sync2 & ~sync3 is a one-`clk` pulse per ulpi rising edge.
- States are IDLE, TURN, RX, TX and STOP.
- IDLE: `data_out`=0, `stp`=0.
  - `dir`=1 goes to TURN.
  - Otherwise, `shift_out`=1 loads the buffer into a shift register and goes to TX.
- TURN: the bus turnaround period, in which `data_in` is ignored.
  - The first `uedge` with `dir`=1 goes to RX.
  - `dir`=0 goes to IDLE.
- RX: evaluated every `clk`.
  - `dir`=1 and `nxt`=1: register `internal_data_out` <= `data_in` and set `new_byte`=1.
  - `dir`=1 and `nxt`=0: the byte is an RX CMD. Clear `new_byte` and hold `internal_data_out`.
  - `dir`=0: clear `new_byte` and go to IDLE.
- TX:
  - `data_out` = low byte of the shift register, so byte 0 appears on the `clk` after the load.
  - Each `uedge` shifts right by 8 bits and increments the byte counter. `nxt` is ignored.
  - When byte NUM_BYTES-1 has been presented for one full ulpi period, the next `uedge` goes to STOP.
  - `dir` rising during TX aborts the transfer: go to TURN with `stp`=0.
- STOP: `stp`=1 and `data_out`=0 for one ulpi period. The next `uedge` clears `stp` and goes to IDLE.
- `shift_out` is ignored outside IDLE, and while `dir`=1.

## Timing
- Reset values: state IDLE, `data_out`=0x00, `internal_data_out`=0x00, `new_byte`=0, `stp`=0, shift register and counter cleared.
- Asserting `rst` mid-transfer returns to IDLE immediately and drops `stp`.
- RX latency: `new_byte` and `internal_data_out` are registered, valid one `clk` after `dir`&`nxt`&`data_in` are sampled.
  - `new_byte` is a level signal: it stays high while consecutive data bytes stream.
  - Consumers sample once per ulpi period.
- TX sequence:
  - Load on the `clk` where `shift_out`=1; `data_out`=byte 0 from the next `clk`.
  - Byte k appears 2–3 `clk` after the k-th ulpi rising edge following the load.
  - 66 bytes therefore take 66 ulpi periods, then 1 period of `stp`.

## Structure
- A shared package `usb_pkg` holds the state enum (IDLE/TURN/RX/TX/STOP), `NUM_BYTES` and `BYTE_W`=8.
- One natural sub-module: `ulpi_edge_detect`, the synchroniser plus rising-edge pulse.
- The FSM, RX register and TX shift register/counter stay in the top module.

## Test plan
- Reset: assert `rst` -> all outputs 0, and `new_byte`=0 on release.
- RX CMD only: `dir`=1, `data_in`=0xFF then 0x00, `nxt`=0 -> `new_byte` stays 0.
- RX data:
  - `dir`=1, turnaround, RX CMD 0x10, then `nxt`=1 with `data_in`=0xAA -> within 2 `clk`, `new_byte`=1 and `internal_data_out`=0xAA.
  - Dropping `dir` clears `new_byte`.
- Multiple RX bytes: `nxt`=1 with 0xFF then 0xAA on consecutive ulpi periods -> `internal_data_out` follows each byte and `new_byte` stays 1.
- TX:
  - Stimulus: `internal_data_in`={33{0xAA,0xBB}}, pulse `shift_out`.
  - `data_out`=0xBB before the next ulpi edge.
  - After that, `data_out` alternates 0xAA/0xBB on each ulpi edge for 65 more bytes.
  - On the following edge `stp`=1 for one ulpi period, then IDLE.
- Abort: raise `dir` mid-TX -> TURN, `stp`=0; `shift_out` with `dir`=1 ignored.
